// File: rtl/cpu_ctrl_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | cpu_ctrl_pkg                                                               |
// | State codes, opcodes, IR field positions and opcode class helpers.         |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
package cpu_ctrl_pkg;

    typedef logic [3:0] state_t;

    localparam logic [3:0] S_IDLE = 4'd0;
    localparam logic [3:0] S_T0   = 4'd1;
    localparam logic [3:0] S_T1   = 4'd2;
    localparam logic [3:0] S_T2   = 4'd3;
    localparam logic [3:0] S_T3   = 4'd4;
    localparam logic [3:0] S_T4   = 4'd5;
    localparam logic [3:0] S_T5   = 4'd6;
    localparam logic [3:0] S_T6   = 4'd7;
    localparam logic [3:0] S_T7   = 4'd8;
    localparam logic [3:0] S_HALT = 4'd9;

    localparam logic [4:0] OP_ADD  = 5'b00011;
    localparam logic [4:0] OP_SUB  = 5'b00100;
    localparam logic [4:0] OP_AND  = 5'b00101;
    localparam logic [4:0] OP_OR   = 5'b00110;
    localparam logic [4:0] OP_ROR  = 5'b00111;
    localparam logic [4:0] OP_ROL  = 5'b01000;
    localparam logic [4:0] OP_SHR  = 5'b01001;
    localparam logic [4:0] OP_SHRA = 5'b01010;
    localparam logic [4:0] OP_SHL  = 5'b01011;
    localparam logic [4:0] OP_MUL  = 5'b01111;
    localparam logic [4:0] OP_DIV  = 5'b10000;
    localparam logic [4:0] OP_NEG  = 5'b10001;
    localparam logic [4:0] OP_NOT  = 5'b10010;
    localparam logic [4:0] OP_NOP  = 5'b11010;
    localparam logic [4:0] OP_HALT = 5'b11011;

    localparam int OP_MSB = 31;
    localparam int OP_LSB = 27;
    localparam int RA_MSB = 26;
    localparam int RA_LSB = 23;
    localparam int RB_MSB = 22;
    localparam int RB_LSB = 19;
    localparam int RC_MSB = 18;
    localparam int RC_LSB = 15;

    // Two register sources (rb, rc); includes mul/div.
    function automatic logic is_binary(input logic [4:0] op);
        return op inside {OP_ADD, OP_SUB, OP_AND, OP_OR, OP_ROR, OP_ROL,
                          OP_SHR, OP_SHRA, OP_SHL, OP_MUL, OP_DIV};
    endfunction

    function automatic logic is_unary(input logic [4:0] op);
        return op inside {OP_NEG, OP_NOT};
    endfunction

    function automatic logic is_muldiv(input logic [4:0] op);
        return op inside {OP_MUL, OP_DIV};
    endfunction

    function automatic logic is_legal(input logic [4:0] op);
        return is_binary(op) || is_unary(op) || (op == OP_NOP) || (op == OP_HALT);
    endfunction

endpackage
`default_nettype wire

// File: rtl/control_decode.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | control_decode                                                             |
// | Combinational decode of present state and IR fields into datapath controls.|
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module control_decode
    import cpu_ctrl_pkg::*;
#(
    parameter int NREGS = 16,
    parameter int OPW   = 5
) (
    input  logic [3:0]       state,
    input  logic [31:0]      IR,
    output logic             PCout,
    output logic             Zhighout,
    output logic             Zlowout,
    output logic             MDRout,
    output logic [NREGS-1:0] Rout,
    output logic [NREGS-1:0] Rin,
    output logic             MARin,
    output logic             PCin,
    output logic             MDRin,
    output logic             IRin,
    output logic             Yin,
    output logic             HIin,
    output logic             LOin,
    output logic             ZHighIn,
    output logic             ZLowIn,
    output logic             IncPC,
    output logic             Read,
    output logic [OPW-1:0]   ALUop,
    output logic             Halted
);

    localparam logic [NREGS-1:0] C_ONE = NREGS'(1);

    logic [OPW-1:0]   w_op;
    logic [NREGS-1:0] w_ra_hot;
    logic [NREGS-1:0] w_rb_hot;
    logic [NREGS-1:0] w_rc_hot;
    logic             w_unused_ir;

    assign w_op        = IR[OP_MSB -: OPW];
    assign w_ra_hot    = C_ONE << IR[RA_MSB:RA_LSB];
    assign w_rb_hot    = C_ONE << IR[RB_MSB:RB_LSB];
    assign w_rc_hot    = C_ONE << IR[RC_MSB:RC_LSB];
    assign w_unused_ir = ^IR[RC_LSB-1:0];

    always_comb begin
        PCout    = 1'b0;
        Zhighout = 1'b0;
        Zlowout  = 1'b0;
        MDRout   = 1'b0;
        Rout     = '0;
        Rin      = '0;
        MARin    = 1'b0;
        PCin     = 1'b0;
        MDRin    = 1'b0;
        IRin     = 1'b0;
        Yin      = 1'b0;
        HIin     = 1'b0;
        LOin     = 1'b0;
        ZHighIn  = 1'b0;
        ZLowIn   = 1'b0;
        IncPC    = 1'b0;
        Read     = 1'b0;
        ALUop    = '0;
        Halted   = 1'b0;
        case (state)
            S_T0: begin
                PCout  = 1'b1;
                MARin  = 1'b1;
                IncPC  = 1'b1;
                ZLowIn = 1'b1;
            end
            S_T1: begin
                Zlowout = 1'b1;
                PCin    = 1'b1;
            end
            S_T2: begin
                Read  = 1'b1;
                MDRin = 1'b1;
            end
            S_T3: begin
                MDRout = 1'b1;
                IRin   = 1'b1;
            end
            S_T4: begin
                Rout = w_rb_hot;
                Yin  = 1'b1;
            end
            S_T5: begin
                // Unary ops re-drive rb; everything else supplies rc as the second operand.
                Rout    = is_unary(w_op) ? w_rb_hot : w_rc_hot;
                ALUop   = w_op;
                ZLowIn  = 1'b1;
                ZHighIn = is_muldiv(w_op);
            end
            S_T6: begin
                Zlowout = 1'b1;
                if (is_muldiv(w_op)) begin
                    LOin = 1'b1;
                end else begin
                    Rin = w_ra_hot;
                end
            end
            S_T7: begin
                Zhighout = 1'b1;
                HIin     = 1'b1;
            end
            S_HALT: begin
                Halted = 1'b1;
            end
            default: begin
            end
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/control_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | control_sequencer                                                          |
// | Fetch/decode/execute state machine for the three-register ALU class.       |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module control_sequencer
    import cpu_ctrl_pkg::*;
#(
    parameter int NREGS = 16,
    parameter int OPW   = 5
) (
    input  logic             Clock,
    input  logic             Clear,
    input  logic             Run,
    input  logic             MemRdy,
    input  logic [31:0]      IR,
    output logic             PCout,
    output logic             Zhighout,
    output logic             Zlowout,
    output logic             MDRout,
    output logic [NREGS-1:0] Rout,
    output logic [NREGS-1:0] Rin,
    output logic             MARin,
    output logic             PCin,
    output logic             MDRin,
    output logic             IRin,
    output logic             Yin,
    output logic             HIin,
    output logic             LOin,
    output logic             ZHighIn,
    output logic             ZLowIn,
    output logic             IncPC,
    output logic             Read,
    output logic [OPW-1:0]   ALUop,
    output logic             Halted,
    output logic             Fault
);

    state_t         r_state;
    state_t         w_next;
    logic           r_fault;
    logic [4:0]     w_op;
    logic           w_fault_set;

    assign w_op        = IR[OP_MSB:OP_LSB];
    assign w_fault_set = (r_state == S_T3) && !is_legal(w_op);
    assign Fault       = r_fault;

    always_comb begin
        w_next = S_IDLE;
        case (r_state)
            S_IDLE: w_next = Run ? S_T0 : S_IDLE;
            S_T0:   w_next = S_T1;
            S_T1:   w_next = S_T2;
            S_T2:   w_next = MemRdy ? S_T3 : S_T2;
            S_T3: begin
                if (w_op == OP_NOP) begin
                    w_next = Run ? S_T0 : S_IDLE;
                end else if ((w_op == OP_HALT) || !is_legal(w_op)) begin
                    w_next = S_HALT;
                end else begin
                    w_next = S_T4;
                end
            end
            S_T4:   w_next = S_T5;
            S_T5:   w_next = S_T6;
            S_T6:   w_next = is_muldiv(w_op) ? S_T7 : (Run ? S_T0 : S_IDLE);
            S_T7:   w_next = Run ? S_T0 : S_IDLE;
            S_HALT: w_next = S_HALT;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge Clock or negedge Clear) begin
        if (!Clear) begin
            r_state <= S_IDLE;
            r_fault <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_fault_set) begin
                r_fault <= 1'b1;
            end
        end
    end

    control_decode #(
        .NREGS (NREGS),
        .OPW   (OPW)
    ) u_decode (
        .state    (r_state),
        .IR       (IR),
        .PCout    (PCout),
        .Zhighout (Zhighout),
        .Zlowout  (Zlowout),
        .MDRout   (MDRout),
        .Rout     (Rout),
        .Rin      (Rin),
        .MARin    (MARin),
        .PCin     (PCin),
        .MDRin    (MDRin),
        .IRin     (IRin),
        .Yin      (Yin),
        .HIin     (HIin),
        .LOin     (LOin),
        .ZHighIn  (ZHighIn),
        .ZLowIn   (ZLowIn),
        .IncPC    (IncPC),
        .Read     (Read),
        .ALUop    (ALUop),
        .Halted   (Halted)
    );

endmodule
`default_nettype wire

// File: tb/tb_control_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_control_sequencer                                                       |
// | Directed table, corner sequences and random instructions vs a cycle model. |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_control_sequencer;

    logic        Clock = 1'b0;
    logic        Clear = 1'b0;
    logic        Run = 1'b0;
    logic        MemRdy = 1'b0;
    logic [31:0] IR = '0;
    logic        PCout, Zhighout, Zlowout, MDRout;
    logic [15:0] Rout, Rin;
    logic        MARin, PCin, MDRin, IRin, Yin, HIin, LOin, ZHighIn, ZLowIn, IncPC, Read;
    logic [4:0]  ALUop;
    logic        Halted, Fault;

    int checks = 0;
    int failures = 0;

    always #5 Clock = ~Clock;

    control_sequencer #(.NREGS(16), .OPW(5)) dut (
        .Clock(Clock), .Clear(Clear), .Run(Run), .MemRdy(MemRdy), .IR(IR),
        .PCout(PCout), .Zhighout(Zhighout), .Zlowout(Zlowout), .MDRout(MDRout),
        .Rout(Rout), .Rin(Rin), .MARin(MARin), .PCin(PCin), .MDRin(MDRin),
        .IRin(IRin), .Yin(Yin), .HIin(HIin), .LOin(LOin), .ZHighIn(ZHighIn),
        .ZLowIn(ZLowIn), .IncPC(IncPC), .Read(Read), .ALUop(ALUop),
        .Halted(Halted), .Fault(Fault)
    );

    typedef struct packed {
        logic pcout, zhighout, zlowout, mdrout;
        logic [15:0] rout, rin;
        logic marin, pcin, mdrin, irin, yin, hiin, loin, zhighin, zlowin, incpc, read;
        logic [4:0] aluop;
        logic halted, fault;
    } ctl_t;

    typedef struct {
        logic [31:0] ir;
        int          waits;
        logic [15:0] t4_rout;
        logic [15:0] t5_rout;
        logic [15:0] rin_any;
        logic [4:0]  aluop;
    } vec_t;

    ctl_t exp_q[$];
    ctl_t obs_q[$];

    function automatic ctl_t sample();
        ctl_t c;
        c.pcout = PCout; c.zhighout = Zhighout; c.zlowout = Zlowout; c.mdrout = MDRout;
        c.rout = Rout; c.rin = Rin; c.marin = MARin; c.pcin = PCin; c.mdrin = MDRin;
        c.irin = IRin; c.yin = Yin; c.hiin = HIin; c.loin = LOin; c.zhighin = ZHighIn;
        c.zlowin = ZLowIn; c.incpc = IncPC; c.read = Read; c.aluop = ALUop;
        c.halted = Halted; c.fault = Fault;
        return c;
    endfunction

    function automatic logic [31:0] mk_ir(input logic [4:0] op, input int ra, input int rb, input int rc);
        return {op, 4'(ra), 4'(rb), 4'(rc), 15'd0};
    endfunction

    function automatic logic legal_op(input logic [4:0] op);
        return op inside {[5'd3:5'd11], 5'd15, 5'd16, 5'd17, 5'd18, 5'd26, 5'd27};
    endfunction

    // Expected control words for one instruction, one entry per cycle starting at fetch.
    function automatic void build(input logic [31:0] ir, input int waits);
        ctl_t c;
        logic [4:0]  op;
        logic [15:0] ra_h, rb_h, rc_h;
        op   = ir[31:27];
        ra_h = 16'd1 << ir[26:23];
        rb_h = 16'd1 << ir[22:19];
        rc_h = 16'd1 << ir[18:15];
        exp_q.delete();
        c = '0; c.pcout = 1; c.marin = 1; c.incpc = 1; c.zlowin = 1; exp_q.push_back(c);
        c = '0; c.zlowout = 1; c.pcin = 1; exp_q.push_back(c);
        for (int i = 0; i <= waits; i++) begin
            c = '0; c.read = 1; c.mdrin = 1; exp_q.push_back(c);
        end
        c = '0; c.mdrout = 1; c.irin = 1; exp_q.push_back(c);
        if (op inside {[5'd3:5'd11], 5'd15, 5'd16, 5'd17, 5'd18}) begin
            c = '0; c.rout = rb_h; c.yin = 1; exp_q.push_back(c);
            c = '0; c.rout = (op inside {5'd17, 5'd18}) ? rb_h : rc_h;
            c.aluop = op; c.zlowin = 1; c.zhighin = (op inside {5'd15, 5'd16});
            exp_q.push_back(c);
            if (op inside {5'd15, 5'd16}) begin
                c = '0; c.zlowout = 1; c.loin = 1; exp_q.push_back(c);
                c = '0; c.zhighout = 1; c.hiin = 1; exp_q.push_back(c);
            end else begin
                c = '0; c.zlowout = 1; c.rin = ra_h; exp_q.push_back(c);
            end
        end
    endfunction

    task automatic check(input string name, input ctl_t got, input ctl_t exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    task automatic check_val(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    // Runs one instruction from its T0 cycle. Run drops from cycle drop_at on;
    // Clear is pulsed at cycle clear_at and the instruction is abandoned there.
    task automatic run_instr(input logic [31:0] ir, input int waits, input int drop_at,
                             input int clear_at, input string tag);
        ctl_t s;
        ctl_t z;
        z = '0;
        build(ir, waits);
        obs_q.delete();
        for (int k = 0; k < exp_q.size(); k++) begin
            @(negedge Clock);
            IR = ir;
            if (drop_at >= 0 && k >= drop_at) Run = 1'b0;
            if (k >= 2 && k < 2 + waits) MemRdy = 1'b0;
            else if (k == 2 + waits) MemRdy = 1'b1;
            else MemRdy = 1'($urandom_range(0, 1));
            #1;
            if (k == clear_at) begin
                Clear = 1'b0;
                #1;
                check($sformatf("%s clear_c%0d", tag, k), sample(), z);
                return;
            end
            s = sample();
            obs_q.push_back(s);
            check($sformatf("%s c%0d", tag, k), s, exp_q[k]);
        end
    endtask

    task automatic idle_cycles(input int n, input string tag);
        ctl_t z;
        z = '0;
        for (int i = 0; i < n; i++) begin
            @(negedge Clock);
            #1;
            check($sformatf("%s idle%0d", tag, i), sample(), z);
        end
    endtask

    task automatic start_run();
        ctl_t z;
        z = '0;
        @(negedge Clock);
        Run = 1'b1;
        #1;
        check("start idle", sample(), z);
    endtask

    task automatic do_clear();
        @(negedge Clock);
        Clear = 1'b0;
        Run = 1'b0;
        #2;
        Clear = 1'b1;
    endtask

    task automatic halt_seq(input logic [31:0] ir, input logic flt, input int n, input string tag);
        ctl_t h;
        run_instr(ir, 0, -1, -1, tag);
        h = '0; h.halted = 1'b1; h.fault = flt;
        for (int i = 0; i < n; i++) begin
            @(negedge Clock);
            MemRdy = 1'($urandom_range(0, 1));
            #1;
            check($sformatf("%s hold%0d", tag, i), sample(), h);
        end
    endtask

    vec_t tbl[7];

    initial begin
        ctl_t z;
        logic [15:0] t4, t5, rany;
        logic [4:0]  aop;
        logic [4:0]  rop;
        int          nread;
        logic [4:0]  ops[14];
        z = '0;
        ops = '{5'd3, 5'd4, 5'd5, 5'd6, 5'd7, 5'd8, 5'd9, 5'd10, 5'd11,
                5'd15, 5'd16, 5'd17, 5'd18, 5'd26};

        tbl[0] = '{32'h3A1B8000, 0, 16'h0008, 16'h0080, 16'h0010, 5'h07};
        tbl[1] = '{32'h3A1B8000, 3, 16'h0008, 16'h0080, 16'h0010, 5'h07};
        tbl[2] = '{32'h78A00000, 0, 16'h0010, 16'h0001, 16'h0000, 5'h0F};
        tbl[3] = '{32'hD0000000, 0, 16'h0000, 16'h0000, 16'h0000, 5'h00};
        tbl[4] = '{mk_ir(5'b10001, 2, 5, 9), 0, 16'h0020, 16'h0020, 16'h0004, 5'h11};
        tbl[5] = '{mk_ir(5'b00011, 15, 0, 14), 2, 16'h0001, 16'h4000, 16'h8000, 5'h03};
        tbl[6] = '{mk_ir(5'b10000, 3, 7, 12), 1, 16'h0080, 16'h1000, 16'h0000, 5'h10};

        #1;
        check("reset", sample(), z);
        #10;
        @(negedge Clock);
        Clear = 1'b1;
        idle_cycles(2, "post_reset");
        start_run();

        for (int t = 0; t < 7; t++) begin
            run_instr(tbl[t].ir, tbl[t].waits, -1, -1, $sformatf("tbl%0d", t));
            t4 = '0; t5 = '0; rany = '0; aop = '0; nread = 0;
            foreach (obs_q[i]) begin
                if (obs_q[i].yin) t4 = obs_q[i].rout;
                if (obs_q[i].aluop != 0) begin t5 = obs_q[i].rout; aop = obs_q[i].aluop; end
                rany |= obs_q[i].rin;
                if (obs_q[i].read) nread++;
            end
            check_val($sformatf("tbl%0d read_cycles", t), nread, tbl[t].waits + 1);
            check_val($sformatf("tbl%0d t4_rout", t), t4, tbl[t].t4_rout);
            check_val($sformatf("tbl%0d t5_rout", t), t5, tbl[t].t5_rout);
            check_val($sformatf("tbl%0d rin", t), rany, tbl[t].rin_any);
            check_val($sformatf("tbl%0d aluop", t), aop, tbl[t].aluop);
        end

        // Run dropped during T4: instruction completes, then IDLE.
        run_instr(32'h3A1B8000, 0, 4, -1, "drop");
        idle_cycles(3, "drop");
        start_run();

        // Clear during T5, then restart from fetch.
        run_instr(32'h3A1B8000, 0, -1, 5, "clr");
        #2;
        Clear = 1'b1;
        run_instr(32'h3A1B8000, 1, -1, -1, "after_clr");

        for (int n = 0; n < 40; n++) begin
            rop = ops[$urandom_range(0, 13)];
            run_instr(mk_ir(rop, $urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 15)),
                      $urandom_range(0, 3), -1, -1, $sformatf("rnd%0d", n));
        end

        halt_seq(32'hD8000000, 1'b0, 20, "halt");
        do_clear();
        idle_cycles(1, "halt_cleared");
        start_run();
        halt_seq(32'hF8000000, 1'b1, 5, "illegal");
        do_clear();
        idle_cycles(1, "fault_cleared");
        start_run();
        do begin
            rop = 5'($urandom_range(0, 31));
        end while (legal_op(rop));
        halt_seq(mk_ir(rop, 1, 2, 3), 1'b1, 3, "rnd_illegal");
        do_clear();
        idle_cycles(1, "final");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
